// File: rtl/pulse_swallow_ctrl_pkg.sv
// pulse_swallow_pkg: shared widths, reset defaults, config word type and S saturation helper
package pulse_swallow_pkg;
  localparam int PW_DEF = 8;
  localparam int P_RST_DEF = 10;
  localparam int S_RST_DEF = 0;
  typedef struct packed {
    logic [PW_DEF-1:0] p;
    logic [PW_DEF-1:0] s;
  } cfg_t;
  function automatic logic [PW_DEF-1:0] sat_s(input logic [PW_DEF-1:0] p, input logic [PW_DEF-1:0] s);
    return (s > p) ? p : s;
  endfunction
endpackage

// File: rtl/pulse_swallow_ctrl_if.sv
// pulse_swallow_ctrl_if: (P,S) config handshake from the sigma-delta modulator
interface pulse_swallow_ctrl_if #(parameter int PW = pulse_swallow_pkg::PW_DEF);
  logic [PW-1:0] cfg_p;
  logic [PW-1:0] cfg_s;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_err;
  modport master(output cfg_p, cfg_s, cfg_valid, input cfg_ready, cfg_err);
  modport slave(input cfg_p, cfg_s, cfg_valid, output cfg_ready, cfg_err);
endinterface

// File: rtl/pulse_swallow_ctrl_cfg_slot.sv
// psc_cfg_slot: one-entry pending config register with legality check, popped at frame end
module psc_cfg_slot
  import pulse_swallow_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] in_p,
  input  logic [PW-1:0] in_s,
  input  logic          in_valid,
  input  logic          pop,
  output logic          in_ready,
  output logic          err,
  output logic          full,
  output cfg_t          word
);
  logic xfer;
  assign in_ready = !full;
  assign xfer = in_valid && in_ready;
  // P=0 words are dropped, oversized S is clamped to P; either case flags err for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      err  <= 1'b0;
      word <= '0;
    end else begin
      err <= xfer && (in_p == '0 || in_s > in_p);
      if (xfer && in_p != '0) begin
        full <= 1'b1;
        word <= '{p: in_p, s: sat_s(in_p, in_s)};
      end else if (pop) full <= 1'b0;
    end
  end
endmodule

// File: rtl/pulse_swallow_ctrl.sv
// pulse_swallow_ctrl: P/S frame counter driving 8/9 prescaler MC; PSC_TOGGLE_OUT_EN adds div_tgl
module pulse_swallow_ctrl
  import pulse_swallow_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int P_RST = P_RST_DEF,
  parameter int S_RST = S_RST_DEF
) (
  input  logic clk,
  input  logic rst,
  pulse_swallow_ctrl_if.slave bus,
  output logic mc,
`ifdef PSC_TOGGLE_OUT_EN
  output logic div_tgl,
`else
`endif
  output logic div_pulse
);
  logic [PW-1:0] cnt, p_act, s_act;
  logic last, full, slot_ready, slot_err;
  cfg_t word;
  psc_cfg_slot #(.PW(PW)) u_slot (
    .clk      (clk),
    .rst      (rst),
    .in_p     (bus.cfg_p),
    .in_s     (bus.cfg_s),
    .in_valid (bus.cfg_valid),
    .pop      (last),
    .in_ready (slot_ready),
    .err      (slot_err),
    .full     (full),
    .word     (word)
  );
  assign last = cnt == '0;
  // cnt counts the remaining cycles of the frame, so k<S becomes cnt >= P-S without widening
  assign mc = !rst && (cnt >= p_act - s_act);
  assign div_pulse = !rst && last;
  assign bus.cfg_ready = rst || slot_ready;
  assign bus.cfg_err = !rst && slot_err;
  // frame counter reloads P-1 at frame end, adopting a pending word if one is waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      p_act <= PW'(P_RST);
      s_act <= PW'(S_RST);
      cnt   <= PW'(P_RST - 1);
    end else if (last && full) begin
      p_act <= word.p;
      s_act <= word.s;
      cnt   <= word.p - 1'b1;
    end else cnt <= last ? p_act - 1'b1 : cnt - 1'b1;
  end
`ifdef PSC_TOGGLE_OUT_EN
  // half-rate frame toggle for a ~50% duty output
  always_ff @(posedge clk) begin
    if (rst) div_tgl <= 1'b0;
    else if (last) div_tgl <= !div_tgl;
  end
`else
`endif
endmodule
